mem_req_queue: RTL and testbench
================================

Name: mem_req_queue

Overview:
Request-side front end that sits directly upstream of mem_system and drives its Rd/Wr/Addr/DataIn interface. It buffers processor-side load/store requests in a small in-order FIFO and issues them one at a time, holding each until mem_system returns Done. It returns in-order responses with the hit flag and measured latency, and keeps hit/latency performance counters plus sticky protocol-error flags.

Parameters:
DEPTH, 4, request FIFO entries; power of 2, at least 2
ADDR_W, 16, address width
DATA_W, 32, data width
CNT_W, 32, performance counter width
TIMEOUT, 64, outstanding cycles before err_timeout sets

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
req_valid  in  1  request present
req_ready  out  1  FIFO not full
req_wr  in  1  1=write, 0=read
req_addr  in  ADDR_W  request address
req_wdata  in  DATA_W  write data
resp_valid  out  1  one-cycle response pulse
resp_wr  out  1  response belongs to a write
resp_rdata  out  DATA_W  read data; 0 for writes
resp_hit  out  1  CacheHit captured at Done
resp_lat  out  8  cycles from issue to Done inclusive, saturating at 255
mem_Addr  out  ADDR_W  to mem_system Addr
mem_DataIn  out  DATA_W  to mem_system DataIn
mem_Rd  out  1  to mem_system Rd
mem_Wr  out  1  to mem_system Wr
mem_DataOut  in  DATA_W  from mem_system
mem_Done  in  1  from mem_system
mem_Stall  in  1  from mem_system (observed only, no gating)
mem_CacheHit  in  1  from mem_system
perf_clr  in  1  synchronous clear of perf counters
perf_reqs  out  CNT_W  completed requests
perf_hits  out  CNT_W  completed hits
perf_busy  out  CNT_W  cycles spent in BUSY
err_timeout  out  1  sticky; outstanding request reached TIMEOUT
err_spurious  out  1  sticky; mem_Done seen while IDLE

Behaviour:
- Reset (rst==0 at posedge): FIFO empty, state IDLE, every output 0 except req_ready=1. Any in-flight request is abandoned. mem_Rd/mem_Wr are low from the first cycle of reset.
- FIFO: push when req_valid && req_ready. req_ready = !full. Push is refused when full, even in a pop cycle. Pointers wrap modulo DEPTH. Occupancy runs 0..DEPTH.
- FSM is IDLE, BUSY.
  - IDLE: if FIFO is non-empty, go to BUSY and load the head into the mem_Addr/mem_DataIn registers.
  - BUSY: mem_Rd = !head.wr and mem_Wr = head.wr. Rd/Wr and Addr/DataIn are registered and held stable until the cycle mem_Done is high, inclusive.
  - BUSY with mem_Done==1: pop the FIFO and go to IDLE. Rd/Wr are low for exactly one cycle before the next issue.
- A push into an empty FIFO reaches BUSY two cycles later (push edge, then IDLE→BUSY edge).
- Latency counter: reset to 1 on entering BUSY, incremented each BUSY cycle without Done, saturating at 255. resp_lat equals the counter value in the Done cycle.
- Response: registered. resp_valid pulses for one cycle, the cycle after Done.
  - resp_rdata = mem_DataOut sampled at Done for reads; 0 for writes.
  - resp_hit = mem_CacheHit at Done; resp_wr = head.wr.
  - resp_* data holds until the next response.
- Counters, modulo 2^CNT_W:
  - perf_reqs +1 per Done in BUSY.
  - perf_hits +1 per Done in BUSY with mem_CacheHit.
  - perf_busy +1 per BUSY cycle.
  - perf_clr zeroes all three and overrides a same-cycle increment. perf_clr does not clear the err flags.
- err_timeout: sets when the latency counter equals TIMEOUT in BUSY without Done. The request keeps waiting and is not dropped.
- err_spurious: sets on mem_Done==1 in IDLE. That Done is otherwise ignored: no pop, no response, no count.
- mem_Stall has no effect on issue timing; Rd/Wr are held regardless.
- Err flags clear only on reset.

Test Plan:
- Single read, addr 0x0010; model Done with hit=1, 1 cycle after mem_Rd rises → mem_Rd high 2 cycles; resp_valid pulse; resp_lat=2, resp_hit=1; perf_reqs=1, perf_hits=1.
- Write then read of the same address 0x0020, data 0xDEADBEEF; model misses at 12 cycles → resp_wr=1 then resp_wr=0; resp_rdata=0xDEADBEEF; exactly one Rd/Wr-low cycle between the two issues; both resp_lat=12, resp_hit=0.
- Push 5 requests back-to-back with DEPTH=4 and the model stalling → req_ready=0 after the 4th push; the 5th is accepted only after the first Done; responses arrive in push order.
- Hold mem_Done low for 70 cycles → err_timeout=1 at BUSY cycle 64; resp_lat=70 on the eventual Done; a later request still completes normally.
- Pulse mem_Done in IDLE → err_spurious=1; perf_reqs unchanged; no resp_valid.
- Assert rst=0 mid-BUSY with 3 queued → next cycle mem_Rd/mem_Wr=0, req_ready=1, counters 0; no response for the abandoned requests; a new request after reset completes.

Source files
------------

// File: rtl/mem_req_queue.sv
`timescale 1ns/1ps
// Purpose : in-order request queue that issues one load/store at a time to mem_system and returns responses with hit/latency.
// Latency : a push into an empty queue reaches mem_Rd/mem_Wr 2 cycles later; the response is registered one cycle after mem_Done.
// Backpres: req_ready = !full; a push is refused when full, even in the cycle the head is popped.
//
// Ports:
//   clk, rst          : clock and synchronous active-low reset
//   req_*             : processor-side request (valid/ready handshake)
//   resp_*            : one-cycle response pulse with data, hit flag and issue-to-Done latency
//   mem_*             : mem_system Rd/Wr/Addr/DataIn drive and DataOut/Done/Stall/CacheHit return
//   perf_*            : request/hit/busy-cycle counters with synchronous clear
//   err_*             : sticky timeout and spurious-Done flags, cleared only by reset
module mem_req_queue #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_wr,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_hit,
    output logic [7:0]        resp_lat,
    output logic [ADDR_W-1:0] mem_Addr,
    output logic [DATA_W-1:0] mem_DataIn,
    output logic              mem_Rd,
    output logic              mem_Wr,
    input  logic [DATA_W-1:0] mem_DataOut,
    input  logic              mem_Done,
    input  logic              mem_Stall,
    input  logic              mem_CacheHit,
    input  logic              perf_clr,
    output logic [CNT_W-1:0]  perf_reqs,
    output logic [CNT_W-1:0]  perf_hits,
    output logic [CNT_W-1:0]  perf_busy,
    output logic              err_timeout,
    output logic              err_spurious
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // ---------------------------------------------------------------
    // Request FIFO
    // ---------------------------------------------------------------
    req_t            fifo_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            full, empty, push, pop;
    req_t            head;
    req_t            push_ent;
    state_t          state_q;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign req_ready = !full;
    assign push      = req_valid && !full;
    // The head is only retired by a genuine completion; Done in IDLE is ignored.
    assign pop       = (state_q == BUSY) && mem_Done;
    assign head      = fifo_q[rd_ptr_q];
    assign push_ent  = '{wr: req_wr, addr: req_addr, wdata: req_wdata};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!push && pop) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read when count_q says valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= push_ent;
        end
    end

    // ---------------------------------------------------------------
    // Issue FSM with registered mem_* and resp_* outputs
    // ---------------------------------------------------------------
    logic              mem_rd_q, mem_wr_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_din_q;
    logic [7:0]        lat_q;
    logic              resp_vld_q, resp_wr_q, resp_hit_q;
    logic [DATA_W-1:0] resp_rdata_q;
    logic [7:0]        resp_lat_q;
    logic              err_timeout_q, err_spurious_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= IDLE;
            mem_rd_q       <= 1'b0;
            mem_wr_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_din_q      <= '0;
            lat_q          <= '0;
            resp_vld_q     <= 1'b0;
            resp_wr_q      <= 1'b0;
            resp_rdata_q   <= '0;
            resp_hit_q     <= 1'b0;
            resp_lat_q     <= '0;
            err_timeout_q  <= 1'b0;
            err_spurious_q <= 1'b0;
        end else begin
            resp_vld_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_Done) begin
                        err_spurious_q <= 1'b1;
                    end
                    if (!empty) begin
                        state_q    <= BUSY;
                        mem_rd_q   <= !head.wr;
                        mem_wr_q   <= head.wr;
                        mem_addr_q <= head.addr;
                        mem_din_q  <= head.wdata;
                        lat_q      <= 8'd1;
                    end
                end
                BUSY: begin
                    if (mem_Done) begin
                        // Dropping Rd/Wr here guarantees one idle cycle before the next issue.
                        state_q      <= IDLE;
                        mem_rd_q     <= 1'b0;
                        mem_wr_q     <= 1'b0;
                        resp_vld_q   <= 1'b1;
                        resp_wr_q    <= head.wr;
                        resp_rdata_q <= head.wr ? '0 : mem_DataOut;
                        resp_hit_q   <= mem_CacheHit;
                        resp_lat_q   <= lat_q;
                    end else begin
                        if (lat_q != 8'hFF) begin
                            lat_q <= lat_q + 8'd1;
                        end
                        // Flag only; the request keeps waiting for its Done.
                        if ({24'd0, lat_q} == 32'(TIMEOUT)) begin
                            err_timeout_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Performance counters (clear wins over a same-cycle increment)
    // ---------------------------------------------------------------
    logic [CNT_W-1:0] perf_reqs_q, perf_hits_q, perf_busy_q;

    always_ff @(posedge clk) begin
        if (!rst || perf_clr) begin
            perf_reqs_q <= '0;
            perf_hits_q <= '0;
            perf_busy_q <= '0;
        end else begin
            if (state_q == BUSY) begin
                perf_busy_q <= perf_busy_q + CNT_W'(1);
            end
            if (pop) begin
                perf_reqs_q <= perf_reqs_q + CNT_W'(1);
                if (mem_CacheHit) begin
                    perf_hits_q <= perf_hits_q + CNT_W'(1);
                end
            end
        end
    end

    // mem_Stall is informational only; issue timing never depends on it.
    logic unused_stall;
    assign unused_stall = mem_Stall;

    assign mem_Rd       = mem_rd_q;
    assign mem_Wr       = mem_wr_q;
    assign mem_Addr     = mem_addr_q;
    assign mem_DataIn   = mem_din_q;
    assign resp_valid   = resp_vld_q;
    assign resp_wr      = resp_wr_q;
    assign resp_rdata   = resp_rdata_q;
    assign resp_hit     = resp_hit_q;
    assign resp_lat     = resp_lat_q;
    assign perf_reqs    = perf_reqs_q;
    assign perf_hits    = perf_hits_q;
    assign perf_busy    = perf_busy_q;
    assign err_timeout  = err_timeout_q;
    assign err_spurious = err_spurious_q;

endmodule

// File: tb/tb_mem_req_queue.sv
`timescale 1ns/1ps
// Purpose : self-checking bench for mem_req_queue with a mem_system responder model and in-order scoreboard.
// Latency : responder asserts Done in a chosen BUSY cycle; expected resp_lat is that cycle index (capped at 255).
// Backpres: request driver holds req_valid until req_ready is seen before an edge.
module tb_mem_req_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid, req_wr, req_ready;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid, resp_wr, resp_hit;
    logic [31:0] resp_rdata;
    logic [7:0]  resp_lat;
    logic [15:0] mem_Addr;
    logic [31:0] mem_DataIn, mem_DataOut;
    logic        mem_Rd, mem_Wr, mem_Stall, mem_CacheHit;
    logic        rsp_done, spur_done, mem_done;
    logic        perf_clr;
    logic [31:0] perf_reqs, perf_hits, perf_busy;
    logic        err_timeout, err_spurious;

    assign mem_done = rsp_done | spur_done;

    always #5 clk = ~clk;

    mem_req_queue #(.DEPTH(4), .ADDR_W(16), .DATA_W(32), .CNT_W(32), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_wr(resp_wr), .resp_rdata(resp_rdata),
        .resp_hit(resp_hit), .resp_lat(resp_lat),
        .mem_Addr(mem_Addr), .mem_DataIn(mem_DataIn), .mem_Rd(mem_Rd), .mem_Wr(mem_Wr),
        .mem_DataOut(mem_DataOut), .mem_Done(mem_done), .mem_Stall(mem_Stall),
        .mem_CacheHit(mem_CacheHit), .perf_clr(perf_clr),
        .perf_reqs(perf_reqs), .perf_hits(perf_hits), .perf_busy(perf_busy),
        .err_timeout(err_timeout), .err_spurious(err_spurious)
    );

    typedef struct { bit wr; logic [15:0] addr; logic [31:0] data; } treq_t;
    typedef struct { bit wr; logic [31:0] rdata; bit hit; logic [7:0] lat; } tresp_t;

    treq_t       pend[$];       // accepted requests, in push order
    tresp_t      expq[$];       // expected responses, in completion order
    tresp_t      resp_log[$];   // observed responses
    logic [31:0] mm [logic [15:0]];
    int          total = 0, bad = 0;
    int          fixed_dly = 2, hit_mode = 1, cnt = 0, cur_dly = 1;
    int          m_reqs = 0, m_hits = 0, m_busy = 0, n_resp = 0;
    treq_t       rsp_r;
    tresp_t      rsp_e, mon_e, mon_a;
    bit          rsp_h;

    function automatic logic [31:0] mem_val(input logic [15:0] a);
        return mm.exists(a) ? mm[a] : {16'hC0DE, a};
    endfunction

    // mem_system model: counts BUSY cycles and answers Done in cycle cur_dly.
    initial begin
        rsp_done = 1'b0; mem_DataOut = '0; mem_CacheHit = 1'b0; mem_Stall = 1'b0;
        forever begin
            @(posedge clk); #1;
            rsp_done     = 1'b0;
            mem_DataOut  = $urandom;
            mem_CacheHit = 1'($urandom_range(0, 1));
            mem_Stall    = 1'($urandom_range(0, 1));
            if (!rst) begin
                cnt = 0;
            end else if (mem_Rd || mem_Wr) begin
                cnt++;
                if (cnt == 1) cur_dly = (fixed_dly > 0) ? fixed_dly : int'($urandom_range(1, 8));
                if (cnt == cur_dly) begin
                    rsp_h = (hit_mode == 2) ? 1'($urandom_range(0, 1)) : (hit_mode == 1);
                    rsp_done = 1'b1;
                    mem_CacheHit = rsp_h;
                    total++;
                    if (pend.size() == 0) begin
                        bad++;
                        $display("FAIL issue_unexpected got addr=%h rd=%b wr=%b want no issue", mem_Addr, mem_Rd, mem_Wr);
                    end else begin
                        rsp_r = pend.pop_front();
                        if (mem_Addr !== rsp_r.addr || mem_Wr !== rsp_r.wr || mem_Rd !== !rsp_r.wr ||
                            (rsp_r.wr && mem_DataIn !== rsp_r.data)) begin
                            bad++;
                            $display("FAIL issue_order got wr=%b rd=%b addr=%h din=%h want wr=%b addr=%h din=%h",
                                     mem_Wr, mem_Rd, mem_Addr, mem_DataIn, rsp_r.wr, rsp_r.addr, rsp_r.data);
                        end
                        rsp_e.wr  = rsp_r.wr;
                        rsp_e.hit = rsp_h;
                        rsp_e.lat = (cnt > 255) ? 8'd255 : 8'(cnt);
                        if (rsp_r.wr) begin
                            rsp_e.rdata = '0;
                            mm[rsp_r.addr] = rsp_r.data;
                        end else begin
                            rsp_e.rdata = mem_val(rsp_r.addr);
                            mem_DataOut = rsp_e.rdata;
                        end
                        expq.push_back(rsp_e);
                        m_reqs++;
                        if (rsp_h) m_hits++;
                        m_busy += cnt;
                    end
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Response scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && resp_valid) begin
                n_resp++;
                mon_a.wr = resp_wr; mon_a.rdata = resp_rdata; mon_a.hit = resp_hit; mon_a.lat = resp_lat;
                resp_log.push_back(mon_a);
                total++;
                if (expq.size() == 0) begin
                    bad++;
                    $display("FAIL resp_unexpected got wr=%b rdata=%h want no response", resp_wr, resp_rdata);
                end else begin
                    mon_e = expq.pop_front();
                    if (resp_wr !== mon_e.wr || resp_rdata !== mon_e.rdata || resp_hit !== mon_e.hit || resp_lat !== mon_e.lat) begin
                        bad++;
                        $display("FAIL resp_fields got wr=%b rdata=%h hit=%b lat=%0d want wr=%b rdata=%h hit=%b lat=%0d",
                                 resp_wr, resp_rdata, resp_hit, resp_lat, mon_e.wr, mon_e.rdata, mon_e.hit, mon_e.lat);
                    end
                end
            end
        end
    end

    // Called at a negedge; returns at a negedge after the accepting edge.
    task automatic push_req(input bit wr, input logic [15:0] a, input logic [31:0] d);
        treq_t r;
        bit    ok = 1'b0;
        req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
        for (int i = 0; i < 1000 && !ok; i++) begin
            if (req_ready) begin
                ok = 1'b1;
                r.wr = wr; r.addr = a; r.data = d;
                pend.push_back(r);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        if (!ok) begin
            total++; bad++;
            $display("FAIL push_timeout got req_ready=%b want 1 within 1000 cycles", req_ready);
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (pend.size() == 0 && expq.size() == 0 && !mem_Rd && !mem_Wr && !resp_valid) ok = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++; if (mem_Rd !== 1'b0 || mem_Wr !== 1'b0) begin bad++; $display("FAIL reset_rdwr got rd=%b wr=%b want 0 0", mem_Rd, mem_Wr); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", req_ready); end
        total++; if (resp_valid !== 1'b0 || resp_lat !== 8'd0 || resp_rdata !== 32'd0) begin bad++; $display("FAIL reset_resp got v=%b lat=%0d rd=%h want 0", resp_valid, resp_lat, resp_rdata); end
        total++; if (perf_reqs !== 0 || perf_hits !== 0 || perf_busy !== 0) begin bad++; $display("FAIL reset_perf got %0d %0d %0d want 0 0 0", perf_reqs, perf_hits, perf_busy); end
        total++; if (err_timeout !== 1'b0 || err_spurious !== 1'b0 || mem_Addr !== 16'd0) begin bad++; $display("FAIL reset_err got to=%b sp=%b addr=%h want 0", err_timeout, err_spurious, mem_Addr); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        bit ok; int rd_cycles = 0;
        fixed_dly = 2; hit_mode = 1; resp_log.delete();
        push_req(1'b0, 16'h0010, 32'h0);
        for (int i = 0; i < 12; i++) begin
            if (mem_Rd) rd_cycles++;
            @(negedge clk);
        end
        wait_idle(ok);
        total++; if (!ok) begin bad++; $display("FAIL single_drain got busy want idle"); end
        total++; if (rd_cycles != 2) begin bad++; $display("FAIL single_rd_cycles got %0d want 2", rd_cycles); end
        total++; if (resp_log.size() != 1) begin bad++; $display("FAIL single_count got %0d want 1", resp_log.size()); end
        else begin
            total++; if (resp_log[0].lat !== 8'd2 || resp_log[0].hit !== 1'b1) begin bad++; $display("FAIL single_lat_hit got lat=%0d hit=%b want 2 1", resp_log[0].lat, resp_log[0].hit); end
        end
        total++; if (perf_reqs !== 32'd1 || perf_hits !== 32'd1 || perf_busy !== 32'd2) begin bad++; $display("FAIL single_perf got %0d %0d %0d want 1 1 2", perf_reqs, perf_hits, perf_busy); end
        total++; if (resp_lat !== 8'd2 || resp_valid !== 1'b0) begin bad++; $display("FAIL single_hold got lat=%0d v=%b want 2 0", resp_lat, resp_valid); end
    endtask

    task automatic test_write_read();
        bit ok; int ph = 0, gap = 0;
        fixed_dly = 12; hit_mode = 0; resp_log.delete();
        push_req(1'b1, 16'h0020, 32'hDEADBEEF);
        push_req(1'b0, 16'h0020, 32'h0);
        for (int i = 0; i < 100; i++) begin
            if (ph == 0 && mem_Wr) ph = 1;
            else if (ph == 1 && mem_Rd) break;
            else if (ph == 1 && !mem_Wr) gap++;
            @(negedge clk);
        end
        wait_idle(ok);
        total++; if (!ok) begin bad++; $display("FAIL wr_rd_drain got busy want idle"); end
        total++; if (gap != 1) begin bad++; $display("FAIL wr_rd_gap got %0d want 1", gap); end
        total++; if (resp_log.size() != 2) begin bad++; $display("FAIL wr_rd_count got %0d want 2", resp_log.size()); end
        else begin
            total++; if (resp_log[0].wr !== 1'b1 || resp_log[1].wr !== 1'b0) begin bad++; $display("FAIL wr_rd_order got %b %b want 1 0", resp_log[0].wr, resp_log[1].wr); end
            total++; if (resp_log[1].rdata !== 32'hDEADBEEF || resp_log[0].rdata !== 32'h0) begin bad++; $display("FAIL wr_rd_data got %h %h want 0 deadbeef", resp_log[0].rdata, resp_log[1].rdata); end
            total++; if (resp_log[0].lat !== 8'd12 || resp_log[1].lat !== 8'd12 || resp_log[0].hit !== 1'b0 || resp_log[1].hit !== 1'b0) begin
                bad++; $display("FAIL wr_rd_lat got %0d %0d hit %b %b want 12 12 0 0", resp_log[0].lat, resp_log[1].lat, resp_log[0].hit, resp_log[1].hit); end
        end
    endtask

    task automatic test_full();
        bit ok, acc = 1'b0, saw = 1'b0;
        treq_t r;
        fixed_dly = 20; hit_mode = 2; resp_log.delete();
        for (int i = 0; i < 4; i++) push_req(1'b0, 16'(32'h0100 + 4 * i), 32'h0);
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL full_ready got %b want 0", req_ready); end
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0110; req_wdata = 32'h0;
        for (int i = 0; i < 100; i++) begin
            if (req_ready) begin acc = 1'b1; break; end
            if (mem_done) saw = 1'b1;
            @(negedge clk);
        end
        if (acc) begin r.wr = 1'b0; r.addr = 16'h0110; r.data = 32'h0; pend.push_back(r); end
        @(negedge clk);
        req_valid = 1'b0;
        total++; if (!acc || !saw) begin bad++; $display("FAIL full_fifth got accepted=%b blocked_in_done=%b want 1 1", acc, saw); end
        wait_idle(ok);
        total++; if (!ok) begin bad++; $display("FAIL full_drain got busy want idle"); end
        total++; if (resp_log.size() != 5) begin bad++; $display("FAIL full_count got %0d want 5", resp_log.size()); end
        else begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (resp_log[i].rdata !== {16'hC0DE, 16'(32'h0100 + 4 * i)}) begin
                    bad++; $display("FAIL full_order idx=%0d got %h want %h", i, resp_log[i].rdata, {16'hC0DE, 16'(32'h0100 + 4 * i)});
                end
            end
        end
    endtask

    task automatic test_timeout();
        bit ok; bit reached = 1'b0;
        fixed_dly = 70; hit_mode = 0; resp_log.delete();
        push_req(1'b0, 16'h0040, 32'h0);
        for (int i = 0; i < 200; i++) begin
            if (cnt == 64) begin reached = 1'b1; break; end
            @(negedge clk);
        end
        total++; if (!reached || err_timeout !== 1'b0) begin bad++; $display("FAIL timeout_early got reached=%b err=%b want 1 0", reached, err_timeout); end
        @(negedge clk);
        total++; if (err_timeout !== 1'b1 || mem_Rd !== 1'b1) begin bad++; $display("FAIL timeout_set got err=%b rd=%b want 1 1", err_timeout, mem_Rd); end
        wait_idle(ok);
        total++; if (!ok || resp_log.size() != 1 || resp_lat !== 8'd70) begin bad++; $display("FAIL timeout_lat got n=%0d lat=%0d want 1 70", resp_log.size(), resp_lat); end
        fixed_dly = 300;
        push_req(1'b1, 16'h0044, 32'h1234_5678);
        wait_idle(ok);
        total++; if (!ok || resp_lat !== 8'd255) begin bad++; $display("FAIL lat_saturate got %0d want 255", resp_lat); end
        fixed_dly = 3; resp_log.delete();
        push_req(1'b0, 16'h0044, 32'h0);
        wait_idle(ok);
        total++; if (!ok || resp_log.size() != 1 || resp_rdata !== 32'h1234_5678 || resp_lat !== 8'd3) begin
            bad++; $display("FAIL timeout_after got n=%0d rdata=%h lat=%0d want 1 12345678 3", resp_log.size(), resp_rdata, resp_lat); end
        total++; if (perf_busy !== 32'(m_busy) || err_timeout !== 1'b1) begin bad++; $display("FAIL timeout_busy got %0d err=%b want %0d 1", perf_busy, err_timeout, m_busy); end
    endtask

    task automatic test_spurious();
        logic [31:0] reqs0, busy0;
        resp_log.delete();
        total++; if (err_spurious !== 1'b0) begin bad++; $display("FAIL spur_pre got %b want 0", err_spurious); end
        reqs0 = perf_reqs; busy0 = perf_busy;
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (err_spurious !== 1'b1) begin bad++; $display("FAIL spur_flag got %b want 1", err_spurious); end
        total++; if (perf_reqs !== reqs0 || perf_busy !== busy0 || resp_log.size() != 0) begin
            bad++; $display("FAIL spur_ignored got reqs=%0d busy=%0d resp=%0d want %0d %0d 0", perf_reqs, perf_busy, resp_log.size(), reqs0, busy0); end
    endtask

    task automatic test_perf_clr();
        bit ok; bit seen = 1'b0;
        fixed_dly = 3; hit_mode = 1;
        push_req(1'b0, 16'h0050, 32'h0);
        for (int i = 0; i < 50; i++) begin
            if (mem_done) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        perf_clr = 1'b1;
        @(negedge clk);
        perf_clr = 1'b0;
        m_reqs = 0; m_hits = 0; m_busy = 0;
        wait_idle(ok);
        total++; if (!seen || perf_reqs !== 0 || perf_hits !== 0 || perf_busy !== 0) begin
            bad++; $display("FAIL clr_override got seen=%b %0d %0d %0d want 1 0 0 0", seen, perf_reqs, perf_hits, perf_busy); end
        total++; if (err_timeout !== 1'b1 || err_spurious !== 1'b1) begin bad++; $display("FAIL clr_keeps_err got %b %b want 1 1", err_timeout, err_spurious); end
        fixed_dly = 2;
        push_req(1'b0, 16'h0054, 32'h0);
        wait_idle(ok);
        total++; if (!ok || perf_reqs !== 32'd1 || perf_busy !== 32'd2) begin bad++; $display("FAIL clr_resume got %0d %0d want 1 2", perf_reqs, perf_busy); end
    endtask

    task automatic test_random();
        bit ok; int n0;
        fixed_dly = 0; hit_mode = 2;
        n0 = n_resp;
        for (int i = 0; i < 40; i++) begin
            push_req(1'($urandom_range(0, 1)), 16'(32'h0200 + 4 * $urandom_range(0, 7)), $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle(ok);
        total++; if (!ok || n_resp - n0 != 40) begin bad++; $display("FAIL rand_count got %0d want 40", n_resp - n0); end
        total++; if (perf_reqs !== 32'(m_reqs) || perf_hits !== 32'(m_hits) || perf_busy !== 32'(m_busy)) begin
            bad++; $display("FAIL rand_perf got %0d %0d %0d want %0d %0d %0d", perf_reqs, perf_hits, perf_busy, m_reqs, m_hits, m_busy); end
    endtask

    task automatic test_reset_busy();
        bit ok;
        fixed_dly = 1000; hit_mode = 1; resp_log.delete();
        for (int i = 0; i < 4; i++) push_req(1'b0, 16'(32'h0300 + 4 * i), 32'h0);
        total++; if (mem_Rd !== 1'b1 || req_ready !== 1'b0) begin bad++; $display("FAIL rstb_pre got rd=%b ready=%b want 1 0", mem_Rd, req_ready); end
        rst = 1'b0;
        @(negedge clk);
        pend.delete(); expq.delete();
        m_reqs = 0; m_hits = 0; m_busy = 0;
        total++; if (mem_Rd !== 1'b0 || mem_Wr !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL rstb_outputs got rd=%b wr=%b ready=%b want 0 0 1", mem_Rd, mem_Wr, req_ready); end
        total++; if (perf_reqs !== 0 || perf_busy !== 0 || err_timeout !== 1'b0 || err_spurious !== 1'b0) begin
            bad++; $display("FAIL rstb_counters got %0d %0d err %b %b want 0 0 0 0", perf_reqs, perf_busy, err_timeout, err_spurious); end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (resp_log.size() != 0 || mem_Rd !== 1'b0) begin bad++; $display("FAIL rstb_abandon got resp=%0d rd=%b want 0 0", resp_log.size(), mem_Rd); end
        fixed_dly = 3;
        push_req(1'b0, 16'h0080, 32'h0);
        wait_idle(ok);
        total++; if (!ok || resp_log.size() != 1 || perf_reqs !== 32'd1 || resp_lat !== 8'd3) begin
            bad++; $display("FAIL rstb_after got n=%0d reqs=%0d lat=%0d want 1 1 3", resp_log.size(), perf_reqs, resp_lat); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got no finish want finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
        spur_done = 1'b0; perf_clr = 1'b0;
        test_reset();
        test_single_read();
        test_write_read();
        test_full();
        test_timeout();
        test_spurious();
        test_perf_clr();
        test_random();
        test_reset_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
